axil_reg_slave: RTL and testbench

AXI-lite responder that terminates the peripheral AXI-lite port driven by the CPU data-bus demux. It exposes NUM_REGS 32-bit registers at BASE_ADDR. Writable registers drive fabric logic through a flat output bus. Read-only registers return live status from fabric inputs. One outstanding write and one outstanding read are supported, and the two paths operate independently.

---
 rtl/axil_reg_slave.sv | 221 ++++++++++++++++++++++
 tb/tb_axil_reg_slave.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_reg_slave.sv
// AXI-lite register slave: NUM_REGS 32-bit registers at BASE_ADDR with byte strobes,
// read-only status registers sourced from reg_in, and independent single-outstanding read/write paths.
module axil_reg_slave #(
    parameter int unsigned         NUM_REGS  = 16,
    parameter logic [31:0]         BASE_ADDR = 32'h0001_0000,
    parameter logic [NUM_REGS-1:0] RO_MASK   = '0
) (
    input  logic                     clk,
    input  logic                     rstf,

    input  logic [31:0]              s_axi_awaddr,
    input  logic [2:0]               s_axi_awprot,
    input  logic                     s_axi_awvalid,
    output logic                     s_axi_awready,
    input  logic [31:0]              s_axi_wdata,
    input  logic [3:0]               s_axi_wstrb,
    input  logic                     s_axi_wvalid,
    output logic                     s_axi_wready,
    output logic [1:0]               s_axi_bresp,
    output logic                     s_axi_bvalid,
    input  logic                     s_axi_bready,

    input  logic [31:0]              s_axi_araddr,
    input  logic [2:0]               s_axi_arprot,
    input  logic                     s_axi_arvalid,
    output logic                     s_axi_arready,
    output logic [31:0]              s_axi_rdata,
    output logic [1:0]               s_axi_rresp,
    output logic                     s_axi_rvalid,
    input  logic                     s_axi_rready,

    output logic [NUM_REGS*32-1:0]   reg_out,
    input  logic [NUM_REGS*32-1:0]   reg_in,
    output logic [NUM_REGS-1:0]      reg_wr_pulse
);

    localparam int unsigned IDX_W  = $clog2(NUM_REGS);
    localparam logic [31:0] SPAN   = 32'(NUM_REGS * 4);
    localparam logic [1:0]  OKAY   = 2'b00;
    localparam logic [1:0]  SLVERR = 2'b10;

    logic [NUM_REGS-1:0][31:0] regs_q;

    // Write-path state
    logic                aw_full_q, aw_full_d;
    logic                w_full_q, w_full_d;
    logic [31:0]         awaddr_q, awaddr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [3:0]          wstrb_q, wstrb_d;
    logic                bvalid_q, bvalid_d;
    logic [1:0]          bresp_q, bresp_d;
    logic [NUM_REGS-1:0] pulse_q, pulse_d;

    // Read-path state
    logic                rvalid_q, rvalid_d;
    logic [31:0]         rdata_q, rdata_d;
    logic [1:0]          rresp_q, rresp_d;

    logic                aw_hs, w_hs, ar_hs, commit;
    logic [31:0]         wr_addr, wr_data, wr_off;
    logic [3:0]          wr_strb;
    logic [IDX_W-1:0]    wr_idx;
    logic                wr_ok;
    logic [NUM_REGS-1:0] wr_en;
    logic [31:0]         rd_off, rd_word;
    logic [IDX_W-1:0]    rd_idx;
    logic                rd_hit;

    // The protection attributes carry no meaning for a flat register file.
    logic unused_prot;
    assign unused_prot = ^{s_axi_awprot, s_axi_arprot};

    assign s_axi_awready = ~aw_full_q & ~bvalid_q;
    assign s_axi_wready  = ~w_full_q & ~bvalid_q;
    assign s_axi_arready = ~rvalid_q;

    assign aw_hs  = s_axi_awvalid & s_axi_awready;
    assign w_hs   = s_axi_wvalid & s_axi_wready;
    assign ar_hs  = s_axi_arvalid & s_axi_arready;
    assign commit = (aw_full_q | aw_hs) & (w_full_q | w_hs);

    // Address and data may come from the holding registers or straight off the bus.
    assign wr_addr = aw_full_q ? awaddr_q : s_axi_awaddr;
    assign wr_data = w_full_q ? wdata_q : s_axi_wdata;
    assign wr_strb = w_full_q ? wstrb_q : s_axi_wstrb;
    assign wr_off  = wr_addr - BASE_ADDR;
    assign wr_idx  = wr_off[IDX_W+1:2];
    assign wr_ok   = (wr_off < SPAN) & ~RO_MASK[wr_idx];

    // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        wr_en = '0;
        if (commit && wr_ok) begin
            wr_en[wr_idx] = 1'b1;
        end
    end

    always_comb begin
        aw_full_d = aw_full_q;
        awaddr_d  = awaddr_q;
        w_full_d  = w_full_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        pulse_d   = wr_en;

        if (aw_hs) begin
            aw_full_d = 1'b1;
            awaddr_d  = s_axi_awaddr;
        end
        if (w_hs) begin
            w_full_d = 1'b1;
            wdata_d  = s_axi_wdata;
            wstrb_d  = s_axi_wstrb;
        end

        if (commit) begin
            aw_full_d = 1'b0;
            w_full_d  = 1'b0;
            bvalid_d  = 1'b1;
            bresp_d   = wr_ok ? OKAY : SLVERR;
        end else if (bvalid_q && s_axi_bready) begin
            bvalid_d = 1'b0;
        end
    end

    // NOTE: sequential state is updated only with non-blocking assignments.
    always_ff @(posedge clk or negedge rstf) begin
        if (!rstf) begin
            aw_full_q <= 1'b0;
            awaddr_q  <= '0;
            w_full_q  <= 1'b0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= OKAY;
            pulse_q   <= '0;
        end else begin
            aw_full_q <= aw_full_d;
            awaddr_q  <= awaddr_d;
            w_full_q  <= w_full_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            pulse_q   <= pulse_d;
        end
    end

    // NOTE: the register file is built from flops, not RAM, so it is reset like any other state.
    // Read-only entries are never enabled and therefore remain constant zero.
    always_ff @(posedge clk or negedge rstf) begin
        if (!rstf) begin
            regs_q <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wr_en[i]) begin
                    for (int k = 0; k < 4; k++) begin
                        if (wr_strb[k]) begin
                            regs_q[i][8*k +: 8] <= wr_data[8*k +: 8];
                        end
                    end
                end
            end
        end
    end

    assign rd_off = s_axi_araddr - BASE_ADDR;
    assign rd_idx = rd_off[IDX_W+1:2];
    assign rd_hit = rd_off < SPAN;

    always_comb begin
        rd_word = regs_q[rd_idx];
        if (RO_MASK[rd_idx]) begin
            rd_word = reg_in[{rd_idx, 5'd0} +: 32];
        end
    end

    always_comb begin
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        if (ar_hs) begin
            rvalid_d = 1'b1;
            rdata_d  = rd_hit ? rd_word : 32'h0;
            rresp_d  = rd_hit ? OKAY : SLVERR;
        end else if (rvalid_q && s_axi_rready) begin
            rvalid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstf) begin
        if (!rstf) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rresp_q  <= OKAY;
        end else begin
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            rresp_q  <= rresp_d;
        end
    end

    always_comb begin
        reg_out = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (!RO_MASK[i]) begin
                reg_out[32*i +: 32] = regs_q[i];
            end
        end
    end

    assign s_axi_bvalid = bvalid_q;
    assign s_axi_bresp  = bresp_q;
    assign s_axi_rvalid = rvalid_q;
    assign s_axi_rdata  = rdata_q;
    assign s_axi_rresp  = rresp_q;
    assign reg_wr_pulse = pulse_q;

endmodule

// File: tb/tb_axil_reg_slave.sv
// Bench for axil_reg_slave: a transaction-level register model checked against the DUT every
// falling edge, plus directed transfers with hand-computed expected values.
module tb_axil_reg_slave;

    localparam int          N    = 16;
    localparam logic [31:0] BASE = 32'h0001_0000;

    logic            clk = 1'b0;
    logic            rstf;
    logic [31:0]     awaddr, wdata, araddr, rdata;
    logic [3:0]      wstrb;
    logic            awvalid, awready, wvalid, wready, bvalid, bready;
    logic            arvalid, arready, rvalid, rready;
    logic [1:0]      bresp, rresp;
    logic [N*32-1:0] reg_out, reg_in;
    logic [N-1:0]    reg_wr_pulse;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    axil_reg_slave #(.NUM_REGS(N), .BASE_ADDR(BASE), .RO_MASK(16'h0001)) dut (
        .clk(clk), .rstf(rstf),
        .s_axi_awaddr(awaddr), .s_axi_awprot(3'b000), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
        .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
        .s_axi_araddr(araddr), .s_axi_arprot(3'b000), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
        .reg_out(reg_out), .reg_in(reg_in), .reg_wr_pulse(reg_wr_pulse)
    );

    task automatic check(input string name, input logic [511:0] got, input logic [511:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // Transaction-level model: register array, pending address/data, expected response queues.
    logic [31:0] m_regs [N];
    logic [31:0] m_aw_q [$];
    logic [31:0] m_wd_q [$];
    logic [3:0]  m_ws_q [$];
    logic [1:0]  m_b_q  [$];
    logic [31:0] m_rd_q [$];
    logic [1:0]  m_rr_q [$];
    logic [N-1:0] m_pulse;

    always @(posedge clk or negedge rstf) begin
        if (!rstf) begin
            for (int i = 0; i < N; i++) m_regs[i] = 32'h0;
            m_aw_q.delete(); m_wd_q.delete(); m_ws_q.delete();
            m_b_q.delete(); m_rd_q.delete(); m_rr_q.delete();
            m_pulse = '0;
        end else begin
            logic ar_acc, aw_acc, w_acc;
            logic [31:0] off, a, d, nv;
            logic [3:0] s;
            int idx;
            ar_acc = arvalid && m_rd_q.size() == 0;
            aw_acc = awvalid && m_aw_q.size() == 0 && m_b_q.size() == 0;
            w_acc  = wvalid && m_wd_q.size() == 0 && m_b_q.size() == 0;
            m_pulse = '0;
            if (m_b_q.size() > 0 && bready) void'(m_b_q.pop_front());
            if (m_rd_q.size() > 0 && rready) begin
                void'(m_rd_q.pop_front());
                void'(m_rr_q.pop_front());
            end
            if (ar_acc) begin
                off = araddr - BASE;
                if (off < N * 4) begin
                    idx = int'(off / 4);
                    m_rd_q.push_back(idx == 0 ? reg_in[31:0] : m_regs[idx]);
                    m_rr_q.push_back(2'b00);
                end else begin
                    m_rd_q.push_back(32'h0);
                    m_rr_q.push_back(2'b10);
                end
            end
            if (aw_acc) m_aw_q.push_back(awaddr);
            if (w_acc) begin
                m_wd_q.push_back(wdata);
                m_ws_q.push_back(wstrb);
            end
            if (m_aw_q.size() > 0 && m_wd_q.size() > 0) begin
                a = m_aw_q.pop_front();
                d = m_wd_q.pop_front();
                s = m_ws_q.pop_front();
                off = a - BASE;
                idx = int'(off / 4);
                if (off < N * 4 && idx != 0) begin
                    nv = m_regs[idx];
                    for (int k = 0; k < 4; k++) if (s[k]) nv[8*k +: 8] = d[8*k +: 8];
                    m_regs[idx] = nv;
                    m_pulse[idx] = 1'b1;
                    m_b_q.push_back(2'b00);
                end else begin
                    m_b_q.push_back(2'b10);
                end
            end
        end
    end

    always @(negedge clk) begin
        logic [N*32-1:0] flat;
        for (int i = 0; i < N; i++) flat[32*i +: 32] = m_regs[i];
        check("reg_out", reg_out, flat);
        check("reg_wr_pulse", reg_wr_pulse, m_pulse);
        check("bvalid", bvalid, m_b_q.size() > 0);
        if (m_b_q.size() > 0) check("bresp", bresp, m_b_q[0]);
        check("awready", awready, m_aw_q.size() == 0 && m_b_q.size() == 0);
        check("wready", wready, m_wd_q.size() == 0 && m_b_q.size() == 0);
        check("arready", arready, m_rd_q.size() == 0);
        check("rvalid", rvalid, m_rd_q.size() > 0);
        if (m_rd_q.size() > 0) begin
            check("rdata", rdata, m_rd_q[0]);
            check("rresp", rresp, m_rr_q[0]);
        end
        if (!rstf) begin
            check("rst_rdata", rdata, 32'h0);
            check("rst_bresp", bresp, 2'b00);
            check("rst_rresp", rresp, 2'b00);
        end
    end

    // W is presented 'lead' cycles before AW; lat counts falling edges from commit to bvalid.
    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int lead, output logic [1:0] resp, output logic [N-1:0] pulse,
                            output int lat);
        bit aw_done = 0, w_done = 0, aw_hit, w_hit, seen = 0, done = 0;
        int cyc = 0;
        resp = 2'bxx; pulse = 'x; lat = -1;
        awaddr = addr; wdata = data; wstrb = strb;
        while (!(aw_done && w_done) && cyc < 100) begin
            awvalid = !aw_done && cyc >= lead;
            wvalid  = !w_done;
            @(negedge clk);
            aw_hit = awvalid && awready;
            w_hit  = wvalid && wready;
            @(posedge clk); #1;
            aw_done |= aw_hit;
            w_done  |= w_hit;
            cyc++;
        end
        awvalid = 1'b0; wvalid = 1'b0;
        check("wr_handshake_done", aw_done && w_done, 1'b1);
        cyc = 0;
        while (!done && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (bvalid && !seen) begin
                seen = 1; lat = cyc; resp = bresp; pulse = reg_wr_pulse;
            end
            if (bvalid && bready) begin
                @(posedge clk); #1;
                done = 1;
            end
        end
        check("wr_response_done", done, 1'b1);
    endtask

    task automatic do_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp,
                           output int lat);
        bit hit = 0, seen = 0, done = 0;
        int cyc = 0;
        data = 'x; resp = 2'bxx; lat = -1;
        araddr = addr; arvalid = 1'b1;
        while (!hit && cyc < 100) begin
            @(negedge clk);
            hit = arready;
            @(posedge clk); #1;
            cyc++;
        end
        arvalid = 1'b0;
        check("rd_handshake_done", hit, 1'b1);
        cyc = 0;
        while (!done && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (rvalid && !seen) begin
                seen = 1; lat = cyc; data = rdata; resp = rresp;
            end
            if (rvalid && rready) begin
                @(posedge clk); #1;
                done = 1;
            end
        end
        check("rd_response_done", done, 1'b1);
    endtask

    logic [1:0]   r_resp, w_resp;
    logic [N-1:0] w_pulse;
    logic [31:0]  r_data;
    logic [N*32-1:0] snap;
    int w_lat, r_lat;

    initial begin
        rstf = 1'b0;
        awaddr = '0; wdata = '0; wstrb = '0; araddr = '0;
        awvalid = 0; wvalid = 0; arvalid = 0; bready = 1; rready = 1;
        reg_in = '0;
        reg_in[31:0]  = 32'hCAFE0001;
        reg_in[63:32] = 32'h5555AAAA;
        repeat (3) @(negedge clk);
        check("reset_bvalid", bvalid, 1'b0);
        check("reset_rvalid", rvalid, 1'b0);
        check("reset_reg_out", reg_out, '0);
        #2 rstf = 1'b1;
        @(posedge clk); #1;

        // Full-word write with AW and W together, then read back.
        do_write(BASE + 32'h4, 32'hDEADBEEF, 4'hF, 0, w_resp, w_pulse, w_lat);
        check("t1_bresp", w_resp, 2'b00);
        check("t1_blat", w_lat, 1);
        check("t1_pulse", w_pulse, 16'h0002);
        check("t1_reg1", reg_out[63:32], 32'hDEADBEEF);
        check("t1_model_reg1", m_regs[1], 32'hDEADBEEF);
        do_read(BASE + 32'h4, r_data, r_resp, r_lat);
        check("t1_rdata", r_data, 32'hDEADBEEF);
        check("t1_rresp", r_resp, 2'b00);
        check("t1_rlat", r_lat, 1);

        // Partial strobes with W leading AW by three cycles.
        do_write(BASE + 32'h8, 32'hFFFFFFFF, 4'hF, 0, w_resp, w_pulse, w_lat);
        do_write(BASE + 32'h8, 32'h11223344, 4'b0101, 3, w_resp, w_pulse, w_lat);
        check("t2_bresp", w_resp, 2'b00);
        check("t2_pulse", w_pulse, 16'h0004);
        check("t2_reg2", reg_out[95:64], 32'hFF22FF44);
        check("t2_model_reg2", m_regs[2], 32'hFF22FF44);

        // Out-of-range accesses, unaligned hit, and the last register.
        snap = reg_out;
        do_write(BASE + N * 4, 32'h12345678, 4'hF, 0, w_resp, w_pulse, w_lat);
        check("t3_bresp_oor", w_resp, 2'b10);
        check("t3_pulse_oor", w_pulse, 16'h0000);
        check("t3_unchanged", reg_out, snap);
        do_read(32'h0, r_data, r_resp, r_lat);
        check("t3_rdata_oor", r_data, 32'h0);
        check("t3_rresp_oor", r_resp, 2'b10);
        do_read(BASE - 32'h4, r_data, r_resp, r_lat);
        check("t3_rresp_below", r_resp, 2'b10);
        do_read(BASE + 32'h6, r_data, r_resp, r_lat);
        check("t3_rdata_unaligned", r_data, 32'hDEADBEEF);
        do_write(BASE + 32'h3C, 32'hA5A5A5A5, 4'hF, 1, w_resp, w_pulse, w_lat);
        check("t3_pulse_last", w_pulse, 16'h8000);
        check("t3_reg15", reg_out[511:480], 32'hA5A5A5A5);

        // Read-only register and zero-strobe write.
        do_read(BASE, r_data, r_resp, r_lat);
        check("t4_ro_rdata", r_data, 32'hCAFE0001);
        check("t4_ro_rresp", r_resp, 2'b00);
        do_write(BASE, 32'hFFFFFFFF, 4'hF, 0, w_resp, w_pulse, w_lat);
        check("t4_ro_bresp", w_resp, 2'b10);
        check("t4_ro_pulse", w_pulse, 16'h0000);
        check("t4_ro_reg_out", reg_out[31:0], 32'h0);
        do_write(BASE + 32'hC, 32'hFFFFFFFF, 4'h0, 0, w_resp, w_pulse, w_lat);
        check("t4_nostrb_bresp", w_resp, 2'b00);
        check("t4_nostrb_pulse", w_pulse, 16'h0008);
        check("t4_nostrb_reg3", reg_out[127:96], 32'h0);

        // Stalled B channel with a concurrent same-edge read of the register being written.
        bready = 1'b0;
        fork
            do_write(BASE + 32'h4, 32'h0BADF00D, 4'hF, 0, w_resp, w_pulse, w_lat);
            do_read(BASE + 32'h4, r_data, r_resp, r_lat);
            begin
                int n = 0;
                while (!bvalid && n < 50) begin @(negedge clk); n++; end
                repeat (5) @(posedge clk);
                #1 bready = 1'b1;
            end
        join
        check("t5_rdata_prewrite", r_data, 32'hDEADBEEF);
        check("t5_rlat", r_lat, 1);
        check("t5_bresp", w_resp, 2'b00);
        check("t5_reg1", reg_out[63:32], 32'h0BADF00D);

        // Reset while both a B and an R response are pending.
        bready = 1'b0; rready = 1'b0;
        awaddr = BASE + 32'h8; wdata = 32'h12345678; wstrb = 4'hF; araddr = BASE + 32'h8;
        awvalid = 1; wvalid = 1; arvalid = 1;
        @(posedge clk); #1;
        awvalid = 0; wvalid = 0; arvalid = 0;
        @(negedge clk);
        check("t6_pre_bvalid", bvalid, 1'b1);
        check("t6_pre_rvalid", rvalid, 1'b1);
        #2 rstf = 1'b0;
        #1;
        check("t6_rst_bvalid", bvalid, 1'b0);
        check("t6_rst_rvalid", rvalid, 1'b0);
        check("t6_rst_reg_out", reg_out, '0);
        check("t6_rst_pulse", reg_wr_pulse, '0);
        @(negedge clk);
        #2 rstf = 1'b1;
        bready = 1'b1; rready = 1'b1;
        @(posedge clk); #1;
        do_read(BASE + 32'h8, r_data, r_resp, r_lat);
        check("t6_reg2_cleared", r_data, 32'h0);
        check("t6_rresp", r_resp, 2'b00);
        do_write(BASE + 32'h4, 32'h00C0FFEE, 4'hF, 0, w_resp, w_pulse, w_lat);
        check("t6_post_bresp", w_resp, 2'b00);
        check("t6_post_pulse", w_pulse, 16'h0002);
        check("t6_post_reg1", reg_out[63:32], 32'h00C0FFEE);

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running expected=finished");
        $fatal(1, "bench timeout");
    end

endmodule
